// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state numbering common to uart_rx and uart_tx,
// frame width and default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        START   = 3'b001,
        DATA    = 3'b010,
        STOP    = 3'b011,
        CLEANUP = 3'b100
    } uart_state_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter.
// Pointers wrap modulo FIFO_DEPTH; occupancy is tracked in a separate counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [UART_DATA_BITS-1:0]   push_data,
    input  logic                        pop,
    output logic [UART_DATA_BITS-1:0]   pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Every state's line level and done flag appear one clock after the state is entered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_N,
    input  logic                      i_Tx_DV,
    input  logic [UART_DATA_BITS-1:0] i_Tx_Byte,
    output logic                      o_Tx_Ready,
    output logic                      o_Tx_Active,
    output logic                      o_Tx_Serial,
    output logic                      o_Tx_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    uart_state_t               state;
    logic [CNT_W-1:0]          clk_count;
    logic [IDX_W-1:0]          bit_index;
    logic [UART_DATA_BITS-1:0] shift;

    logic                      push;
    logic                      pop;
    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             occ_next;
    logic                      bit_end;

    assign push     = i_Tx_DV & o_Tx_Ready & ~fifo_full;
    assign pop      = (state == IDLE) & ~fifo_empty;
    assign occ_next = fifo_count + CW'(push) - CW'(pop);
    assign bit_end  = (clk_count == CNT_W'(CLKS_PER_BIT - 1));

    assign o_Tx_Active = (state != IDLE);

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (i_Clock),
        .rst_n     (i_Rst_N),
        .push      (push),
        .push_data (i_Tx_Byte),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state       <= IDLE;
            clk_count   <= '0;
            bit_index   <= '0;
            shift       <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Done   <= 1'b0;
            o_Tx_Ready  <= 1'b0;
        end else begin
            o_Tx_Ready <= (occ_next < CW'(FIFO_DEPTH));
            o_Tx_Done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    clk_count   <= '0;
                    bit_index   <= '0;
                    if (pop) begin
                        shift <= fifo_data;
                        state <= START;
                    end
                end
                START: begin
                    o_Tx_Serial <= 1'b0;
                    if (bit_end) begin
                        clk_count <= '0;
                        state     <= DATA;
                    end else begin
                        clk_count <= clk_count + CNT_W'(1);
                    end
                end
                DATA: begin
                    o_Tx_Serial <= shift[bit_index];
                    if (bit_end) begin
                        clk_count <= '0;
                        if (bit_index == IDX_W'(UART_DATA_BITS - 1)) begin
                            bit_index <= '0;
                            state     <= STOP;
                        end else begin
                            bit_index <= bit_index + IDX_W'(1);
                        end
                    end else begin
                        clk_count <= clk_count + CNT_W'(1);
                    end
                end
                STOP: begin
                    o_Tx_Serial <= 1'b1;
                    if (bit_end) begin
                        clk_count <= '0;
                        state     <= CLEANUP;
                    end else begin
                        clk_count <= clk_count + CNT_W'(1);
                    end
                end
                CLEANUP: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Done   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frame vectors, directed
// FIFO/reset sequences and randomized traffic against a frame decoder.
module tb_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       tx_active;
    logic       tx_serial;
    logic       tx_done;

    int checks;
    int errors;

    uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_N     (rst_n),
        .i_Tx_DV     (tx_dv),
        .i_Tx_Byte   (tx_byte),
        .o_Tx_Ready  (tx_ready),
        .o_Tx_Active (tx_active),
        .o_Tx_Serial (tx_serial),
        .o_Tx_Done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame decoder: expected bytes queue up in exp_q when accepted.
    logic [7:0] exp_q[$];
    int         gaps[$];
    bit         mon_en;
    int         frames_seen;
    int         high_run;
    int         done_pulses;
    logic [7:0] m_got;
    bit         m_start_ok;
    bit         m_stop_ok;
    bit         m_done_early;
    bit         m_done_ok;

    always @(posedge clk) begin
        if (tx_done) done_pulses++;
    end

    initial begin
        frames_seen = 0;
        high_run    = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                high_run = 0;
            end else if (tx_serial) begin
                high_run++;
            end else begin
                if (frames_seen > 0) gaps.push_back(high_run);
                high_run     = 0;
                m_got        = '0;
                m_start_ok   = 1'b1;
                m_stop_ok    = 1'b0;
                m_done_early = 1'b0;
                m_done_ok    = 1'b0;
                for (int s = 1; s <= 40; s++) begin
                    @(negedge clk);
                    if (tx_serial) high_run++;
                    else high_run = 0;
                    if (s < 40 && tx_done) m_done_early = 1'b1;
                    if (s == 40) m_done_ok = tx_done;
                    if (s % C == C / 2) begin
                        if (s / C == 0) m_start_ok = !tx_serial;
                        else if (s / C == 9) m_stop_ok = tx_serial;
                        else m_got[s / C - 1] = tx_serial;
                    end
                end
                check("mon_start", m_start_ok, 1);
                check("mon_stop", m_stop_ok, 1);
                check("mon_done_early", m_done_early, 0);
                check("mon_done_pos", m_done_ok, 1);
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_frame", m_got, 32'hFFFF_FFFF);
                end else begin
                    check("mon_byte", m_got, exp_q.pop_front());
                end
                frames_seen++;
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[6];

    // Send one byte and compare the line slot by slot against a frame literal.
    task automatic tx_vector(input logic [7:0] b, input logic [9:0] exp);
        int lows;
        int zeros;
        bit early;
        lows  = 0;
        zeros = 0;
        early = 0;
        for (int k = 0; k < 10; k++) if (!exp[k]) zeros++;
        @(negedge clk);
        check("vec_ready", tx_ready, 1);
        tx_dv   = 1'b1;
        tx_byte = b;
        @(negedge clk);
        tx_dv   = 1'b0;
        tx_byte = ~b;
        check("vec_n0_high", tx_serial, 1);
        @(negedge clk);
        check("vec_n1_high", tx_serial, 1);
        check("vec_active", tx_active, 1);
        for (int c = 0; c < 10 * C; c++) begin
            @(negedge clk);
            if (!tx_serial) lows++;
            if (tx_done) early = 1;
            if (c % C == C / 2)
                check($sformatf("vec_%0h_slot%0d", b, c / C), tx_serial, exp[c / C]);
        end
        check("vec_done_early", early, 0);
        @(negedge clk);
        check("vec_done", tx_done, 1);
        check("vec_line_after", tx_serial, 1);
        @(negedge clk);
        check("vec_done_one_cycle", tx_done, 0);
        check("vec_idle", tx_active, 0);
        check($sformatf("vec_%0h_low_cycles", b), lows, zeros * C);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    int  base_gap;
    int  base_done;
    int  n_acc;
    int  wait_n;
    bit  bad_serial;
    bit  bad_done;
    bit  bad_active;
    bit  bad_ready;

    initial begin
        checks  = 0;
        errors  = 0;
        mon_en  = 0;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        rst_n   = 1'b0;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'hFF, 10'b1111111110};
        vecs[2] = '{8'h00, 10'b1000000000};
        vecs[3] = '{8'h01, 10'b1000000010};
        vecs[4] = '{8'h3C, 10'b1001111000};
        vecs[5] = '{8'h80, 10'b1100000000};

        // Reset and idle
        bad_serial = 0; bad_done = 0; bad_active = 0; bad_ready = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_serial !== 1'b1) bad_serial = 1;
            if (tx_done !== 1'b0) bad_done = 1;
            if (tx_active !== 1'b0) bad_active = 1;
            if (tx_ready !== 1'b0) bad_ready = 1;
        end
        check("rst_serial", bad_serial, 0);
        check("rst_done", bad_done, 0);
        check("rst_active", bad_active, 0);
        check("rst_ready", bad_ready, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", tx_ready, 0);
        @(negedge clk);
        check("ready_after_release", tx_ready, 1);
        check("idle_serial", tx_serial, 1);
        repeat (2) @(negedge clk);

        // Table-driven frames, including 0xFF then 0x00 boundaries
        for (int i = 0; i < 6; i++) begin
            tx_vector(vecs[i].data, vecs[i].frame);
            repeat (2) @(negedge clk);
        end

        // Simultaneous push and pop
        mon_en = 1;
        @(negedge clk);
        tx_dv = 1'b1; tx_byte = 8'h5A; exp_q.push_back(8'h5A);
        @(negedge clk);
        check("sim_count_after_push", dut.u_fifo.count, 1);
        tx_byte = 8'hC3; exp_q.push_back(8'hC3);
        @(negedge clk);
        tx_dv = 1'b0;
        check("sim_count_push_pop", dut.u_fifo.count, 1);
        check("sim_ready", tx_ready, 1);
        drain("sim_drain", 300);

        // FIFO fill and back-to-back frames
        base_gap  = gaps.size();
        base_done = done_pulses;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("fill_ready_%0d", i), tx_ready, 1);
            tx_dv   = 1'b1;
            tx_byte = 8'(i + 1);
            exp_q.push_back(8'(i + 1));
        end
        @(negedge clk);
        tx_dv = 1'b0;
        check("fill_full", tx_ready, 0);
        repeat (10) @(negedge clk);
        check("fill_still_full", tx_ready, 0);
        drain("fill_drain", 600);
        check("fill_done_pulses", done_pulses - base_done, 5);
        check("fill_gap_count", gaps.size() - base_gap, 5);
        for (int i = 1; i < 5; i++)
            if (base_gap + i < gaps.size())
                check($sformatf("fill_gap_%0d", i), gaps[base_gap + i], C + 2);

        // Reset mid-frame
        mon_en = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_dv   = 1'b1;
            tx_byte = (i == 0) ? 8'h00 : 8'(8'hAA + i);
        end
        @(negedge clk);
        tx_dv  = 1'b0;
        wait_n = 0;
        while (tx_serial && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("mid_start_seen", tx_serial, 0);
        repeat (4 * C + 1) @(negedge clk);
        check("mid_bit3_low", tx_serial, 0);
        check("mid_active", tx_active, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_serial", tx_serial, 1);
        check("mid_rst_active", tx_active, 0);
        check("mid_rst_ready", tx_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_ready_back", tx_ready, 1);
        bad_serial = 0; bad_done = 0; bad_active = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_serial !== 1'b1) bad_serial = 1;
            if (tx_done !== 1'b0) bad_done = 1;
            if (tx_active !== 1'b0) bad_active = 1;
        end
        check("mid_no_frames_serial", bad_serial, 0);
        check("mid_no_frames_done", bad_done, 0);
        check("mid_no_frames_active", bad_active, 0);

        // Randomized traffic against the frame decoder
        mon_en = 1;
        n_acc  = 0;
        for (int cyc = 0; cyc < 4000 && n_acc < 25; cyc++) begin
            @(negedge clk);
            tx_dv   = ($urandom_range(0, 3) == 0);
            tx_byte = 8'($urandom);
            if (tx_dv && tx_ready) begin
                exp_q.push_back(tx_byte);
                n_acc++;
            end
        end
        @(negedge clk);
        tx_dv = 1'b0;
        check("rand_accepted", n_acc, 25);
        drain("rand_drain", 2000);
        check("rand_idle_ready", tx_ready, 1);
        check("rand_idle_line", tx_serial, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
